// File: rtl/vga_scan_controller.sv
// ----------------------------------------------------------------------------
// vga_scan_controller
//
// Raster scan generator for a VGA style display. A small FSM (IDLE, RUN,
// STOPPING) gates a pair of 10-bit pixel/line counters that advance on every
// cycle where pix_tick is high. Sync, visible-area and status pulse outputs
// are decoded combinationally from the registered state and counters, so
// they line up with pixel_x/pixel_y with no extra latency.
//
// Ports
//   clk          system clock, rising edge active
//   reset_n      asynchronous active-low reset
//   pix_tick     pixel enable; counters move only when high
//   start        level request to begin scanning
//   stop         level request to halt at the end of the current frame
//   pixel_x      current column, 0..H_TOTAL-1
//   pixel_y      current row, 0..V_TOTAL-1
//   hsync        active-low horizontal sync
//   vsync        active-low vertical sync
//   video_on     current pixel lies in the visible area
//   line_done    pulse on the last pixel tick of a line
//   frame_done   pulse on the last pixel tick of a frame
//   frame_start  pulse on the pixel tick at (0,0)
//   busy         FSM is not IDLE
// ----------------------------------------------------------------------------
module vga_scan_controller #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_tick,
    input  logic       start,
    input  logic       stop,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_done,
    output logic       frame_done,
    output logic       frame_start,
    output logic       busy
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SYNC_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]  H_SYNC_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_SYNC_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  V_SYNC_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    // One bit wider so a visible width of exactly 1024 still compares correctly.
    localparam logic [10:0] H_VIS_LIMIT  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_LIMIT  = 11'(V_VISIBLE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic x_last;
    logic y_last;
    logic wrap_tick;

    assign x_last    = (pixel_x == H_LAST);
    assign y_last    = (pixel_y == V_LAST);
    // Last pixel tick of the frame: both counters are about to roll over.
    assign wrap_tick = pix_tick & x_last & y_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In STOPPING the end of frame takes priority over a fresh start request,
    // and a start only cancels the pending stop when stop itself has dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = STOPPING;
                end
            end
            STOPPING: begin
                if (wrap_tick) begin
                    state_next = IDLE;
                end else if (start && !stop) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters sit at the origin while IDLE, so every run begins at (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x <= 10'd0;
            pixel_y <= 10'd0;
        end else if (state == IDLE) begin
            pixel_x <= 10'd0;
            pixel_y <= 10'd0;
        end else if (pix_tick) begin
            if (x_last) begin
                pixel_x <= 10'd0;
                pixel_y <= y_last ? 10'd0 : pixel_y + 10'd1;
            end else begin
                pixel_x <= pixel_x + 10'd1;
            end
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        hsync       = !(busy && (pixel_x >= H_SYNC_FIRST) && (pixel_x <= H_SYNC_LAST));
        vsync       = !(busy && (pixel_y >= V_SYNC_FIRST) && (pixel_y <= V_SYNC_LAST));
        video_on    = busy && ({1'b0, pixel_x} < H_VIS_LIMIT) && ({1'b0, pixel_y} < V_VIS_LIMIT);
        line_done   = busy && pix_tick && x_last;
        frame_done  = busy && wrap_tick;
        frame_start = busy && pix_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
    end

endmodule

// File: tb/tb_vga_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_vga_scan_controller
//
// Self-checking bench. Horizontal timing uses the design defaults (800 pixel
// lines); vertical timing is shortened to 12 lines so whole frames stay cheap.
// The reference model tracks the scan as one linear position within the
// frame plus two flags (scanning, stop pending) and derives every expected
// output from that position with plain division/modulo.
// ----------------------------------------------------------------------------
module tb_vga_scan_controller;

    localparam int HV    = 640;
    localparam int HF    = 16;
    localparam int HS    = 96;
    localparam int HB    = 48;
    localparam int HT    = HV + HF + HS + HB;
    localparam int VV    = 6;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 2;
    localparam int VT    = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       pix_tick = 1'b0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_done;
    logic       frame_done;
    logic       frame_start;
    logic       busy;

    logic [26:0] observed;
    assign observed = {pixel_x, pixel_y, hsync, vsync, video_on,
                       line_done, frame_done, frame_start, busy};

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_active       = 1'b0;
    bit m_stop_pending = 1'b0;
    int m_pos          = 0;

    vga_scan_controller #(
        .V_VISIBLE (VV),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_tick    (pix_tick),
        .start       (start),
        .stop        (stop),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .line_done   (line_done),
        .frame_done  (frame_done),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Expected output vector for the current model position and current pix_tick.
    function automatic logic [26:0] expected_outputs();
        int x;
        int y;
        logic hs, vs, vo, ld, fd, fs;
        x  = m_pos % HT;
        y  = m_pos / HT;
        hs = !(m_active && x >= HV + HF && x < HV + HF + HS);
        vs = !(m_active && y >= VV + VF && y < VV + VF + VS);
        vo = m_active && x < HV && y < VV;
        ld = m_active && pix_tick && x == HT - 1;
        fd = m_active && pix_tick && m_pos == FRAME - 1;
        fs = m_active && pix_tick && m_pos == 0;
        return {10'(x), 10'(y), hs, vs, vo, ld, fd, fs, m_active};
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_step();
        bit wrap;
        if (!reset_n) begin
            m_active       = 1'b0;
            m_stop_pending = 1'b0;
            m_pos          = 0;
        end else if (!m_active) begin
            m_pos = 0;
            if (start) begin
                m_active       = 1'b1;
                m_stop_pending = 1'b0;
            end
        end else begin
            wrap = pix_tick && (m_pos == FRAME - 1);
            if (pix_tick) m_pos = (m_pos + 1) % FRAME;
            if (!m_stop_pending) begin
                if (stop) m_stop_pending = 1'b1;
            end else if (wrap) begin
                m_active       = 1'b0;
                m_stop_pending = 1'b0;
            end else if (start && !stop) begin
                m_stop_pending = 1'b0;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [26:0] exp_v;
        reset_n  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) reset_n = 1'b1;
            start    = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop     = 1'($urandom_range(0, 1));
            pix_tick = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_v = expected_outputs();
            total++;
            if (observed !== exp_v)
                begin bad++; $display("[TB] FAIL reset[%0d]: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b", i, observed[26:17], observed[16:7], observed[6:0], exp_v[26:17], exp_v[16:7], exp_v[6:0]); end
            total++;
            if (observed !== {10'd0, 10'd0, 7'b1100000})
                begin bad++; $display("[TB] FAIL reset_const[%0d]: got %b, expected idle outputs %b", i, observed, {10'd0, 10'd0, 7'b1100000}); end
            advance();
        end
        stop = 1'b0;
    endtask

    task automatic test_start_line();
        logic [26:0] exp_v;
        int x;
        pix_tick = 1'b1;
        stop     = 1'b0;
        for (int i = 0; i < HT + 6; i++) begin
            start = (i == 0);
            @(negedge clk);
            exp_v = expected_outputs();
            total++;
            if (observed !== exp_v)
                begin bad++; $display("[TB] FAIL start_line[%0d]: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b", i, observed[26:17], observed[16:7], observed[6:0], exp_v[26:17], exp_v[16:7], exp_v[6:0]); end
            x = m_pos % HT;
            if (m_active && m_pos == 0) begin
                total++;
                if ({frame_start, video_on, hsync, vsync, busy} !== 5'b11111)
                    begin bad++; $display("[TB] FAIL first_pixel: got fs/vo/hs/vs/busy=%b, expected 11111", {frame_start, video_on, hsync, vsync, busy}); end
            end
            if (m_active && m_pos < HT && (x == 655 || x == 656 || x == 751 || x == 752)) begin
                total++;
                if (hsync !== (x == 655 || x == 752))
                    begin bad++; $display("[TB] FAIL hsync_edge x=%0d: got %b, expected %b", x, hsync, (x == 655 || x == 752)); end
            end
            if (m_active && m_pos == 640) begin
                total++;
                if (video_on !== 1'b0)
                    begin bad++; $display("[TB] FAIL video_off_640: got %b, expected 0", video_on); end
            end
            if (m_active && m_pos == HT) begin
                total++;
                if ({pixel_x, pixel_y} !== {10'd0, 10'd1})
                    begin bad++; $display("[TB] FAIL next_line: got (%0d,%0d), expected (0,1)", pixel_x, pixel_y); end
            end
            advance();
        end
        start = 1'b0;
    endtask

    task automatic test_frame_wrap();
        logic [26:0] exp_v;
        int tail;
        bit done;
        tail     = -1;
        done     = 1'b0;
        stop     = 1'b0;
        pix_tick = 1'b1;
        for (int i = 0; i < 2 * FRAME && !done; i++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_v = expected_outputs();
            total++;
            if (observed !== exp_v)
                begin bad++; $display("[TB] FAIL frame_wrap[%0d]: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b", i, observed[26:17], observed[16:7], observed[6:0], exp_v[26:17], exp_v[16:7], exp_v[6:0]); end
            if (m_active && m_pos == FRAME - 1) begin
                tail = 4;
                total++;
                if ({line_done, frame_done} !== 2'b11)
                    begin bad++; $display("[TB] FAIL wrap_pulses: got line_done/frame_done=%b, expected 11", {line_done, frame_done}); end
            end
            advance();
            if (tail > 0) begin
                tail--;
                if (tail == 0) done = 1'b1;
            end
        end
        start = 1'b0;
        total++;
        if (!done)
            begin bad++; $display("[TB] FAIL frame_wrap_timeout: got no wrap, expected one within %0d cycles", 2 * FRAME); end
    endtask

    task automatic test_stop();
        logic [26:0] exp_v;
        int phase;
        int idle_cycles;
        int fd_count;
        phase       = 0;
        idle_cycles = 0;
        fd_count    = 0;
        for (int i = 0; i < 3 * FRAME && idle_cycles < 6; i++) begin
            start    = 1'b0;
            stop     = 1'b0;
            pix_tick = m_active ? 1'b1 : 1'($urandom_range(0, 1));
            if (phase == 0 && m_pos == 2 * HT + 100) begin
                stop = 1'b1; phase = 1;
            end else if (phase == 1 && m_pos == 4 * HT + 5) begin
                start = 1'b1; phase = 2;
            end else if (phase == 2 && m_pos == 4 * HT + 7) begin
                start = 1'b1; stop = 1'b1; phase = 3;
            end else if (phase == 3 && m_pos == 6 * HT + 10) begin
                start = 1'b1; stop = 1'b1; phase = 4;
            end
            @(negedge clk);
            exp_v = expected_outputs();
            total++;
            if (observed !== exp_v)
                begin bad++; $display("[TB] FAIL stop[%0d]: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b", i, observed[26:17], observed[16:7], observed[6:0], exp_v[26:17], exp_v[16:7], exp_v[6:0]); end
            if (frame_done === 1'b1) fd_count++;
            advance();
            if (phase == 4 && !m_active) idle_cycles++;
        end
        start = 1'b0;
        stop  = 1'b0;
        total++;
        if (idle_cycles < 6 || fd_count != 1)
            begin bad++; $display("[TB] FAIL stop_sequence: got idle_cycles=%0d frame_done_count=%0d, expected 6 and 1", idle_cycles, fd_count); end
    endtask

    task automatic test_sparse_tick();
        logic [26:0] exp_v;
        int hold;
        hold = 0;
        stop = 1'b0;
        for (int i = 0; i < 4 * (HT + 40); i++) begin
            start = (i == 0);
            if (m_active && m_pos % HT == HT - 1 && hold < 6) begin
                pix_tick = 1'b0;
                hold++;
            end else begin
                pix_tick = (i % 4 == 0);
            end
            @(negedge clk);
            exp_v = expected_outputs();
            total++;
            if (observed !== exp_v)
                begin bad++; $display("[TB] FAIL sparse[%0d]: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b", i, observed[26:17], observed[16:7], observed[6:0], exp_v[26:17], exp_v[16:7], exp_v[6:0]); end
            if (m_active && !pix_tick && m_pos % HT == HT - 1) begin
                total++;
                if (line_done !== 1'b0)
                    begin bad++; $display("[TB] FAIL line_done_held: got %b, expected 0", line_done); end
            end
            advance();
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        logic [26:0] exp_v;
        for (int i = 0; i < 20000; i++) begin
            start    = ($urandom_range(0, 63) == 0);
            stop     = ($urandom_range(0, 255) == 0);
            pix_tick = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_v = expected_outputs();
            total++;
            if (observed !== exp_v)
                begin bad++; $display("[TB] FAIL random[%0d]: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b", i, observed[26:17], observed[16:7], observed[6:0], exp_v[26:17], exp_v[16:7], exp_v[6:0]); end
            advance();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [26:0] exp_v;
        bit reached;
        reached  = 1'b0;
        stop     = 1'b0;
        pix_tick = 1'b1;
        for (int i = 0; i < 2 * FRAME + 4 && !reached; i++) begin
            start = (i == 0);
            @(negedge clk);
            exp_v = expected_outputs();
            total++;
            if (observed !== exp_v)
                begin bad++; $display("[TB] FAIL pre_reset[%0d]: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b", i, observed[26:17], observed[16:7], observed[6:0], exp_v[26:17], exp_v[16:7], exp_v[6:0]); end
            advance();
            if (m_active && m_pos == 3 * HT + 400) reached = 1'b1;
        end
        start = 1'b0;
        total++;
        if (!reached)
            begin bad++; $display("[TB] FAIL reset_target_timeout: got no visit to (400,3), expected one"); end
        #2;
        reset_n        = 1'b0;
        m_active       = 1'b0;
        m_stop_pending = 1'b0;
        m_pos          = 0;
        #1;
        total++;
        if (observed !== {10'd0, 10'd0, 7'b1100000})
            begin bad++; $display("[TB] FAIL async_reset: got %b, expected %b before next edge", observed, {10'd0, 10'd0, 7'b1100000}); end
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) reset_n = 1'b1;
            start    = (i < 3);
            stop     = 1'($urandom_range(0, 1));
            pix_tick = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_v = expected_outputs();
            total++;
            if (observed !== exp_v)
                begin bad++; $display("[TB] FAIL post_reset[%0d]: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b", i, observed[26:17], observed[16:7], observed[6:0], exp_v[26:17], exp_v[16:7], exp_v[6:0]); end
            advance();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_line();
        test_frame_wrap();
        test_stop();
        test_sparse_tick();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got no completion, expected finish within 5ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
